// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//   Shares one external, purely combinational int_alu between two requesters.
//   Port 0 is the execute stage and port 1 is the branch/address unit.
//   A round-robin arbiter picks one request per cycle. The chosen operands go
//   into a single issue register (S1) that drives the ALU. The ALU result is
//   captured into a per-port response register on the next edge.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   req_valid/ready   per-port request handshake (ready = combinational grant)
//   req_op/alt/a/b    per-port ALU operation and operands
//   req_tag           per-port opaque tag, echoed on the response
//   rsp_valid/ready   per-port response handshake
//   rsp_y/zero/tag    per-port captured result, zero flag and tag
//   alu_op/alt/a/b    to int_alu, driven straight from S1
//   alu_y/zero        from int_alu
// -----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int TAG_W   = 4,
    parameter int RR_INIT = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [5:0]           req_op,
    input  logic [1:0]           req_alt,
    input  logic [63:0]          req_a,
    input  logic [63:0]          req_b,
    input  logic [2*TAG_W-1:0]   req_tag,
    output logic [1:0]           rsp_valid,
    input  logic [1:0]           rsp_ready,
    output logic [63:0]          rsp_y,
    output logic [1:0]           rsp_zero,
    output logic [2*TAG_W-1:0]   rsp_tag,
    output logic [2:0]           alu_op,
    output logic                 alu_alt,
    output logic [31:0]          alu_a,
    output logic [31:0]          alu_b,
    input  logic [31:0]          alu_y,
    input  logic                 alu_zero
);

    localparam logic PRIO_RST = (RR_INIT != 0);

    // Issue stage
    logic             s1_valid_q, s1_valid_d;
    logic             s1_port_q,  s1_port_d;
    logic [2:0]       s1_op_q,    s1_op_d;
    logic             s1_alt_q,   s1_alt_d;
    logic [31:0]      s1_a_q,     s1_a_d;
    logic [31:0]      s1_b_q,     s1_b_d;
    logic [TAG_W-1:0] s1_tag_q,   s1_tag_d;

    // Port currently holding priority when both are eligible
    logic             prio_q, prio_d;

    logic [1:0]       elig;
    logic [1:0]       grant;
    logic             sel;

    // A port may issue only if it is not already in S1 (its result would
    // otherwise land on top of the one in flight) and its response slot is
    // empty or being drained this cycle.
    for (genvar gi = 0; gi < 2; gi++) begin : g_elig
        assign elig[gi] = req_valid[gi]
                        & ~(s1_valid_q & (s1_port_q == 1'(gi)))
                        & (~rsp_valid[gi] | rsp_ready[gi]);
    end

    always_comb begin
        grant = 2'b00;
        if (!rst) begin
            if (&elig) grant = prio_q ? 2'b10 : 2'b01;
            else       grant = elig;
        end
    end

    assign req_ready = grant;
    assign sel       = grant[1];

    always_comb begin
        s1_valid_d = |grant;
        s1_port_d  = s1_port_q;
        s1_op_d    = s1_op_q;
        s1_alt_d   = s1_alt_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_tag_d   = s1_tag_q;
        prio_d     = prio_q;
        if (|grant) begin
            s1_port_d = sel;
            s1_op_d   = sel ? req_op[5:3]  : req_op[2:0];
            s1_alt_d  = sel ? req_alt[1]   : req_alt[0];
            s1_a_d    = sel ? req_a[63:32] : req_a[31:0];
            s1_b_d    = sel ? req_b[63:32] : req_b[31:0];
            s1_tag_d  = sel ? req_tag[2*TAG_W-1:TAG_W] : req_tag[TAG_W-1:0];
            prio_d    = ~sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_port_q  <= 1'b0;
            s1_op_q    <= '0;
            s1_alt_q   <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_tag_q   <= '0;
            prio_q     <= PRIO_RST;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_port_q  <= s1_port_d;
            s1_op_q    <= s1_op_d;
            s1_alt_q   <= s1_alt_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_tag_q   <= s1_tag_d;
            prio_q     <= prio_d;
        end
    end

    assign alu_op  = s1_op_q;
    assign alu_alt = s1_alt_q;
    assign alu_a   = s1_a_q;
    assign alu_b   = s1_b_q;

    // Per-port response registers. Capture of a new result has precedence
    // over draining; eligibility guarantees the slot is free by then.
    for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
        logic             valid_q, valid_d;
        logic [31:0]      y_q,     y_d;
        logic             zero_q,  zero_d;
        logic [TAG_W-1:0] tag_q,   tag_d;
        logic             capture;

        assign capture = s1_valid_q & (s1_port_q == 1'(gi));

        always_comb begin
            valid_d = valid_q;
            y_d     = y_q;
            zero_d  = zero_q;
            tag_d   = tag_q;
            if (capture) begin
                valid_d = 1'b1;
                y_d     = alu_y;
                zero_d  = alu_zero;
                tag_d   = s1_tag_q;
            end else if (valid_q & rsp_ready[gi]) begin
                valid_d = 1'b0;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= 1'b0;
                y_q     <= '0;
                zero_q  <= 1'b0;
                tag_q   <= '0;
            end else begin
                valid_q <= valid_d;
                y_q     <= y_d;
                zero_q  <= zero_d;
                tag_q   <= tag_d;
            end
        end

        assign rsp_valid[gi]                   = valid_q;
        assign rsp_y[32*gi+31 -: 32]           = y_q;
        assign rsp_zero[gi]                    = zero_q;
        assign rsp_tag[TAG_W*gi+TAG_W-1 -: TAG_W] = tag_q;
    end

endmodule
